scanned_debounce_scheduler: RTL
===============================

Name: scanned_debounce_scheduler

Overview:
- Multi-channel input conditioner for N noisy pins (buttons, switches).
- Every channel has its own 2-FF synchronizer. The debounce compare/count logic is a single shared unit, time-multiplexed across channels by a round-robin scan pointer.
- Produces per-channel conditioned levels and one-cycle edge pulses.
- Sits between board pins and the mode/control FSMs, and replaces N separate conditioner instances.

Parameters:
- CHANNELS, 4, number of noisy inputs (2..16).
- WAITTIME, 3, consecutive mismatching scan visits required before conditioned flips (1..2^COUNTERWIDTH-1).
- COUNTERWIDTH, 3, width of each per-channel visit counter; elaboration error if WAITTIME > 2^COUNTERWIDTH-1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  scan enable; synchronizers run regardless.
- noisysignal  in  CHANNELS  raw asynchronous pins.
- conditioned  out  CHANNELS  debounced, synchronized levels.
- positiveedge  out  CHANNELS  one-cycle pulse on conditioned 0->1.
- negativeedge  out  CHANNELS  one-cycle pulse on conditioned 1->0.
- scan_idx  out  $clog2(CHANNELS)  channel currently being evaluated (debug).

Behaviour:
- Reset (reset_n=0 at posedge) clears all registers in the same cycle, mid-operation included: sync0=0, sync1=0, cnt[*]=0, ptr=0, conditioned=0, positiveedge=0, negativeedge=0.
- After reset, a pin held at 1 debounces normally and produces a positiveedge.
- Synchronizer: sync0<=noisysignal; sync1<=sync0 every cycle, all channels.
- Scan pointer:
  - enable=1: ptr advances +1 per cycle, wrapping CHANNELS-1 -> 0.
  - enable=0: ptr holds and no cnt/conditioned updates occur.
  - scan_idx=ptr.
- Visit of channel i=ptr, enable=1, one of three cases:
  - sync1[i]==conditioned[i]: cnt[i]<=0. A bounce back always restarts debounce.
  - Mismatch and cnt[i]<WAITTIME-1: cnt[i]<=cnt[i]+1.
  - Mismatch and cnt[i]==WAITTIME-1 (commit): conditioned[i]<=sync1[i]; cnt[i]<=0. positiveedge[i] (rising) or negativeedge[i] (falling) <=1 for exactly the cycle in which conditioned[i] first shows the new value.
- Unvisited channels: cnt and conditioned hold.
- Edge outputs are registered and default to 0 every cycle.
- At most one channel commits per cycle, so positiveedge|negativeedge is zero or one-hot.
- Latency, pin stable from cycle t: 2 cycles sync; first visit within CHANNELS cycles; commit on WAITTIME-th visit; output next edge. Worst case 2+WAITTIME*CHANNELS+1 cycles (CHANNELS=4, WAITTIME=3: 15). Best case 2+(WAITTIME-1)*CHANNELS+1 (11).
- Glitch shorter than one scan period may be missed entirely; this is intended filtering.

Optional Feature:
- DEBOUNCE_EVENT_PORT_EN.
- Defined: adds ports event_valid out 1, event_ready in 1, event_chan out $clog2(CHANNELS), event_rising out 1.
  - Each commit loads the event register (valid=1, chan=i, rising=new level).
  - event_valid holds, with payload stable, until a cycle with event_ready=1.
  - If a commit would occur while event_valid=1 and event_ready=0, the scanner stalls instead: ptr, cnt and conditioned hold; no edge pulse.
  - Accept and new commit in the same cycle: the new event loads, valid stays 1.
  - Reset clears event_valid.
- Undefined: ports absent; scanner never stalls.

Test Plan:
- All tests use CHANNELS=4, WAITTIME=3.
- Reset, then hold noisysignal=4'b0000 for 40 cycles -> conditioned=0000, no edge pulses, scan_idx cycles 0,1,2,3,0.
- Set noisysignal[0]=1 and hold -> conditioned[0]=1 within 11..15 cycles; positiveedge=4'b0001 for exactly one cycle; other outputs unchanged.
- On ch2, toggle 1,0,1,1,0,0 on consecutive cycles, then hold 0 (conditioned[2]=1 beforehand) -> cnt[2] restarts, conditioned[2] stays 1 until hold completes; then exactly one negativeedge[2] pulse.
- Drive ch1 and ch3 rising on the same cycle -> commits land on different cycles (2 apart); positiveedge never has more than one bit set.
- enable=0 for 20 cycles with ch0 changed -> no commit, scan_idx frozen; enable=1 -> commit within 12 cycles.
- Assert reset_n=0 mid-debounce (cnt[1]=2) -> next cycle all outputs 0, ptr=0. With macro: hold event_ready=0 after an event -> ptr stalls at the next commit, releases on ready=1.

Source files
------------

// File: rtl/scanned_debounce_scheduler.sv
// rtl/scanned_debounce_scheduler.sv - shared, round-robin scanned debouncer for CHANNELS noisy pins
//
// One 2-FF synchronizer per channel feeds a single compare/count unit. A scan
// pointer visits one channel per enabled cycle. A channel's conditioned level
// flips after WAITTIME consecutive visits that disagree with it.
//
// Optional feature macro: DEBOUNCE_EVENT_PORT_EN (adds a valid/ready event port;
// the scanner stalls rather than dropping an event).
//
// Ports:
//   clk           system clock, all logic on posedge
//   reset_n       synchronous active-low reset
//   enable        scan enable (synchronizers always run)
//   noisysignal   raw asynchronous pins            [CHANNELS]
//   conditioned   debounced levels                 [CHANNELS]
//   positiveedge  one-cycle pulse on 0->1 commit   [CHANNELS]
//   negativeedge  one-cycle pulse on 1->0 commit   [CHANNELS]
//   scan_idx      channel visited this cycle       [$clog2(CHANNELS)]
//   event_valid / event_ready / event_chan / event_rising (macro only)

module scanned_debounce_scheduler #(
  parameter int CHANNELS     = 4,
  parameter int WAITTIME     = 3,
  parameter int COUNTERWIDTH = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [CHANNELS-1:0]         noisysignal,
  output logic [CHANNELS-1:0]         conditioned,
  output logic [CHANNELS-1:0]         positiveedge,
  output logic [CHANNELS-1:0]         negativeedge,
  output logic [$clog2(CHANNELS)-1:0] scan_idx
`ifdef DEBOUNCE_EVENT_PORT_EN
  ,
  output logic                        event_valid,
  input  logic                        event_ready,
  output logic [$clog2(CHANNELS)-1:0] event_chan,
  output logic                        event_rising
`endif
);

  localparam int PW = $clog2(CHANNELS);
  localparam logic [COUNTERWIDTH-1:0] CNT_LAST = COUNTERWIDTH'(WAITTIME - 1);
  localparam logic [PW-1:0]           PTR_LAST = PW'(CHANNELS - 1);

  generate
    if (WAITTIME < 1 || WAITTIME > (2 ** COUNTERWIDTH) - 1) begin : g_bad_waittime
      $error("WAITTIME must be in 1..2**COUNTERWIDTH-1");
    end
    if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
      $error("CHANNELS must be in 2..16");
    end
  endgenerate

  logic [CHANNELS-1:0]     sync0;
  logic [CHANNELS-1:0]     sync1;
  logic [COUNTERWIDTH-1:0] cnt [CHANNELS];
  logic [PW-1:0]           ptr;

  logic                    vis_sync;
  logic                    vis_cond;
  logic [COUNTERWIDTH-1:0] vis_cnt;
  logic                    mismatch;
  logic                    at_last;
  logic                    commit;
  logic                    stall;
  logic                    advance;

  assign vis_sync = sync1[ptr];
  assign vis_cond = conditioned[ptr];
  assign vis_cnt  = cnt[ptr];
  assign mismatch = vis_sync != vis_cond;
  assign at_last  = vis_cnt == CNT_LAST;
  assign commit   = enable && mismatch && at_last;

`ifdef DEBOUNCE_EVENT_PORT_EN
  // A commit with an unaccepted event pending would overwrite it, so the whole
  // scan freezes on that channel until the consumer takes the old event.
  assign stall = commit && event_valid && !event_ready;
`else
  assign stall = 1'b0;
`endif

  assign advance  = enable && !stall;
  assign scan_idx = ptr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync0        <= '0;
      sync1        <= '0;
      ptr          <= '0;
      conditioned  <= '0;
      positiveedge <= '0;
      negativeedge <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync0        <= noisysignal;
      sync1        <= sync0;
      positiveedge <= '0;
      negativeedge <= '0;
      if (advance) begin
        ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        if (!mismatch) begin
          // Any visit that agrees with the current level restarts the count.
          cnt[ptr] <= '0;
        end else if (!at_last) begin
          cnt[ptr] <= vis_cnt + 1'b1;
        end else begin
          cnt[ptr]         <= '0;
          conditioned[ptr] <= vis_sync;
          if (vis_sync) begin
            positiveedge[ptr] <= 1'b1;
          end else begin
            negativeedge[ptr] <= 1'b1;
          end
        end
      end
    end
  end

`ifdef DEBOUNCE_EVENT_PORT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      event_valid  <= 1'b0;
      event_chan   <= '0;
      event_rising <= 1'b0;
    end else if (advance && commit) begin
      // Also covers accept-and-load in the same cycle: valid simply stays high.
      event_valid  <= 1'b1;
      event_chan   <= ptr;
      event_rising <= vis_sync;
    end else if (event_ready) begin
      event_valid <= 1'b0;
    end
  end
`endif

endmodule
